layer00_out_writer: RTL and testbench
=====================================

# layer00_out_writer

Packs the four 8-bit per-filter outputs of layer 0 into 128-bit words and writes them into the layer-1 input feature buffer. Sits directly downstream of the layer-0 compute path (parser, weight control, MAC bank, adder tree, additional layer): one pixel per channel is accepted per valid cycle, and every 16th pixel produces one write per channel bank. Frame-level control is a two-state FSM with a wrapping word address and a done pulse.

## Interface
Parameters:
- FRAME_WORDS, 512, 128-bit words per channel per frame (1..512); the frame is FRAME_WORDS*16 pixels.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- iStart  in  1  frame start pulse; arms the block and clears counters
- i_vld  in  1  pixel valid from layer-0 output stage
- i_ch0 .. i_ch3  in  8 each  layer-0 filter 0..3 output pixel
- o_wea  out  4  per-channel-bank write enable, one-cycle pulse
- o_addra  out  9  word write address, shared by all four banks
- o_dia0 .. o_dia3  out  128 each  packed write data for banks 0..3
- o_busy  out  1  high in RUN
- o_done  out  1  one-cycle pulse coincident with the last word write of a frame

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- IDLE: i_vld ignored. iStart -> RUN; lane counter and word counter cleared to 0.
- RUN: each i_vld=1 cycle stores i_chN into byte lane L of channel N's packing register, lane L = bits [8L+7:8L], L = lane counter (0..15). Pixel 0 of a word is bits [7:0].
- Lane counter increments per valid pixel and wraps 15 -> 0. On the valid with L=15, a write is issued: next cycle o_wea=4'b1111, o_dia0..3 = the completed words (including the pixel just accepted), o_addra = word counter.
- Word counter increments after each write. When the write uses address FRAME_WORDS-1: o_done=1 same cycle as o_wea, FSM -> IDLE, word counter wraps to 0.
- iStart while in RUN: restart — lane and word counters cleared, partially filled word discarded (no write), stays in RUN. An i_vld in the same cycle as iStart is dropped.
- A write already scheduled by the previous cycle's L=15 valid still issues even if iStart arrives, at its old address.
- No backpressure: the downstream buffer accepts a write every cycle. i_vld may be high every cycle; the packing register is double-buffered, so a new word fills while the previous one is written.
- Pixel values are passed through unmodified (unsigned 8-bit, no saturation here).

## Timing
- Reset values: o_wea=0, o_addra=0, o_dia0..3=0, o_busy=0, o_done=0; internal lane/word counters and packing registers 0.
- All outputs registered. Latency: 16th pixel sampled at edge k -> o_wea/o_dia/o_addra valid in cycle k+1, for exactly one cycle.
- o_dia and o_addra hold their last written values while o_wea=0.
- o_busy rises the cycle after iStart and falls the cycle after the o_done pulse.
- Continuous i_vld: one write every 16 cycles, back-to-back frames require a new iStart (≥1 cycle in IDLE).
- Reset asserted mid-frame: all state and outputs return to reset values immediately; no write is emitted.

## Structure
- Shared package: LANES=16, PIX_W=8, WORD_W=128, ADDR_W=9, FSM state encoding.
- One sub-module natural: layer00_lane_packer (one channel: 16×8-bit lane shift/insert into 128-bit word plus output hold register), instantiated four times; the top holds FSM, lane counter, word counter and done logic.

## Test plan
- Reset then idle: i_vld toggling with no iStart -> o_wea stays 0, o_busy 0, outputs all 0.
- iStart, then 16 consecutive valids with i_ch0=L, i_ch1=0x10+L, i_ch2=0x20+L, i_ch3=0x30+L -> one cycle later o_wea=4'hF, o_addra=0, o_dia0=0x0F0E…0100, o_dia3=0x3F3E…3130.
- FRAME_WORDS=4, 64 continuous valids -> writes at addresses 0,1,2,3 on cycles 16,32,48,64 after first valid; o_done with the address-3 write; o_busy low next cycle; further valids produce no writes.
- Gapped valids (i_vld every 3rd cycle) -> same packed data as contiguous case, write one cycle after 16th valid.
- iStart after 7 valids in RUN -> partial word discarded; next 16 valids write to address 0 containing only post-restart pixels.
- rstn low after 10 valids -> all outputs 0 immediately; after release and iStart, first write at address 0 with fresh data.

Source files
------------

// File: rtl/layer00_out_writer_pkg.sv
// layer00_out_writer_pkg: shared widths and FSM encoding for the layer-0 output writer.
package layer00_out_writer_pkg;
    localparam int LANES  = 16;
    localparam int LANE_W = 4;
    localparam int PIX_W  = 8;
    localparam int WORD_W = 128;
    localparam int ADDR_W = 9;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/layer00_lane_packer.sv
// layer00_lane_packer: packs 16 pixels of one channel into a 128-bit word with a separate output hold register.
module layer00_lane_packer
    import layer00_out_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr,
    input  logic [LANE_W-1:0] lane,
    input  logic [PIX_W-1:0]  pix,
    output logic [WORD_W-1:0] word
);
    logic [WORD_W-1:0] fill;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill <= '0;
            word <= '0;
        end else begin
            if (clr) fill <= '0;
            else if (wr) fill[lane*PIX_W +: PIX_W] <= pix;
            // last lane bypasses fill so the word completes in the same cycle
            if (wr && lane == LANE_W'(LANES-1)) word <= {pix, fill[WORD_W-PIX_W-1:0]};
        end
    end
endmodule

// File: rtl/layer00_out_writer.sv
// layer00_out_writer: packs four layer-0 channels into 128-bit words and writes them to the layer-1 buffer.
module layer00_out_writer
    import layer00_out_writer_pkg::*;
#(
    parameter int FRAME_WORDS = 512
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iStart,
    input  logic              i_vld,
    input  logic [PIX_W-1:0]  i_ch0,
    input  logic [PIX_W-1:0]  i_ch1,
    input  logic [PIX_W-1:0]  i_ch2,
    input  logic [PIX_W-1:0]  i_ch3,
    output logic [3:0]        o_wea,
    output logic [ADDR_W-1:0] o_addra,
    output logic [WORD_W-1:0] o_dia0,
    output logic [WORD_W-1:0] o_dia1,
    output logic [WORD_W-1:0] o_dia2,
    output logic [WORD_W-1:0] o_dia3,
    output logic              o_busy,
    output logic              o_done
);
    state_t            state;
    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] wordCnt;
    logic              accept, fire, last;
    logic [PIX_W-1:0]  pix [4];
    logic [WORD_W-1:0] dia [4];

    assign accept = state == RUN && i_vld && !iStart;
    assign fire   = accept && lane == LANE_W'(LANES-1);
    assign last   = wordCnt == ADDR_W'(FRAME_WORDS-1);
    assign pix    = '{i_ch0, i_ch1, i_ch2, i_ch3};

    for (genvar c = 0; c < 4; c++) begin : g_pack
        layer00_lane_packer u_pack (
            .clk  (clk),
            .rstn (rstn),
            .clr  (iStart),
            .wr   (accept),
            .lane (lane),
            .pix  (pix[c]),
            .word (dia[c])
        );
    end

    assign o_dia0 = dia[0];
    assign o_dia1 = dia[1];
    assign o_dia2 = dia[2];
    assign o_dia3 = dia[3];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            lane    <= '0;
            wordCnt <= '0;
            o_wea   <= '0;
            o_addra <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_wea  <= {4{fire}};
            o_done <= fire && last;
            // busy stays up through the done cycle and drops one cycle later
            o_busy <= iStart || (o_busy && !o_done);
            if (fire) o_addra <= wordCnt;
            if (iStart) begin
                state   <= RUN;
                lane    <= '0;
                wordCnt <= '0;
            end else if (accept) begin
                lane <= lane + 1'b1;
                if (fire) begin
                    wordCnt <= last ? '0 : wordCnt + 1'b1;
                    if (last) state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_layer00_out_writer.sv
// tb_layer00_out_writer: randomized scoreboard bench for layer00_out_writer with a byte-queue reference model.
module tb_layer00_out_writer;
    localparam int FW = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         iStart = 1'b0;
    logic         i_vld = 1'b0;
    logic [7:0]   i_ch0 = '0, i_ch1 = '0, i_ch2 = '0, i_ch3 = '0;
    logic [3:0]   o_wea;
    logic [8:0]   o_addra;
    logic [127:0] o_dia0, o_dia1, o_dia2, o_dia3;
    logic         o_busy, o_done;

    layer00_out_writer #(.FRAME_WORDS(FW)) dut (
        .clk(clk), .rstn(rstn), .iStart(iStart), .i_vld(i_vld),
        .i_ch0(i_ch0), .i_ch1(i_ch1), .i_ch2(i_ch2), .i_ch3(i_ch3),
        .o_wea(o_wea), .o_addra(o_addra),
        .o_dia0(o_dia0), .o_dia1(o_dia1), .o_dia2(o_dia2), .o_dia3(o_dia3),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               cyc;
        logic [8:0]       addr;
        logic             done;
        logic [3:0][127:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bq0[$], bq1[$], bq2[$], bq3[$];
    bit         running = 0;
    int         wordIdx = 0;
    int         cycCnt = 0;
    int         checks = 0;
    int         errors = 0;

    localparam logic [127:0] PAT0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] PAT3 = 128'h3F3E3D3C3B3A39383736353433323130;

    always @(posedge clk) cycCnt <= cycCnt + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clearModel();
        bq0.delete(); bq1.delete(); bq2.delete(); bq3.delete();
    endtask

    // Reference: collect 16 bytes per channel; byte n of a word sits at bits [8n+7:8n].
    task automatic model(input logic s, input logic v);
        exp_t e;
        if (s) begin
            running = 1;
            wordIdx = 0;
            clearModel();
        end else if (running && v) begin
            bq0.push_back(i_ch0); bq1.push_back(i_ch1);
            bq2.push_back(i_ch2); bq3.push_back(i_ch3);
            if (bq0.size() == 16) begin
                e.cyc  = cycCnt + 1;
                e.addr = 9'(wordIdx);
                e.done = (wordIdx == FW - 1);
                for (int n = 0; n < 16; n++) begin
                    e.d[0][8*n +: 8] = bq0[n];
                    e.d[1][8*n +: 8] = bq1[n];
                    e.d[2][8*n +: 8] = bq2[n];
                    e.d[3][8*n +: 8] = bq3[n];
                end
                sb.push_back(e);
                clearModel();
                wordIdx++;
                if (e.done) running = 0;
            end
        end
    endtask

    task automatic step(input logic s, input logic v, input bit pat, input int l);
        iStart = s;
        i_vld  = v;
        if (pat) begin
            i_ch0 = 8'(l); i_ch1 = 8'(8'h10 + l); i_ch2 = 8'(8'h20 + l); i_ch3 = 8'(8'h30 + l);
        end else begin
            i_ch0 = 8'($urandom); i_ch1 = 8'($urandom); i_ch2 = 8'($urandom); i_ch3 = 8'($urandom);
        end
        model(s, v);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (o_wea != 4'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected write wea %h addr %0d", o_wea, o_addra);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("write_cycle", 128'(cycCnt), 128'(e.cyc));
                    chk("wea", 128'(o_wea), 128'hF);
                    chk("addr", 128'(o_addra), 128'(e.addr));
                    chk("done", 128'(o_done), 128'(e.done));
                    chk("dia0", o_dia0, e.d[0]);
                    chk("dia1", o_dia1, e.d[1]);
                    chk("dia2", o_dia2, e.d[2]);
                    chk("dia3", o_dia3, e.d[3]);
                end
            end else begin
                if (o_done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_without_write got 1 expected 0");
                end
                if (sb.size() != 0 && sb[0].cyc <= cycCnt) begin
                    checks++;
                    errors++;
                    $display("FAIL missing write addr got none expected %0d", sb[0].addr);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_wea", 128'(o_wea), 0);
        chk("rst_addra", 128'(o_addra), 0);
        chk("rst_dia0", o_dia0, 0);
        chk("rst_dia3", o_dia3, 0);
        chk("rst_busy", 128'(o_busy), 0);
        chk("rst_done", 128'(o_done), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) step(0, 1'(i % 2), 0, 0);
        chk("idle_busy", 128'(o_busy), 0);
        chk("idle_dia0", o_dia0, 0);

        step(1, 0, 0, 0);
        chk("busy_rise", 128'(o_busy), 1);
        for (int l = 0; l < 16; l++) step(0, 1, 1, l);
        chk("pat_wea", 128'(o_wea), 128'hF);
        chk("pat_dia0", o_dia0, PAT0);
        chk("pat_dia3", o_dia3, PAT3);
        step(0, 0, 0, 0);
        chk("hold_dia0", o_dia0, PAT0);

        step(1, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 1, 0, 0);
        chk("frame_done", 128'(o_done), 1);
        chk("frame_busy_at_done", 128'(o_busy), 1);
        chk("frame_last_addr", 128'(o_addra), FW - 1);
        step(0, 1, 0, 0);
        chk("frame_busy_fall", 128'(o_busy), 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);

        step(1, 0, 0, 0);
        for (int l = 0; l < 16; l++) begin
            step(0, 1, 1, l);
            if (l != 15) begin
                step(0, 0, 0, 0);
                step(0, 0, 0, 0);
            end
        end
        chk("gap_dia0", o_dia0, PAT0);
        chk("gap_dia3", o_dia3, PAT3);

        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        chk("restart_addr", 128'(o_addra), 0);

        step(1, 0, 0, 0);
        for (int i = 0; i < 26; i++) step(0, 1, 0, 0);
        rstn = 1'b0;
        #1;
        chk("arst_dia0", o_dia0, 0);
        chk("arst_dia2", o_dia2, 0);
        chk("arst_busy", 128'(o_busy), 0);
        chk("arst_wea", 128'(o_wea), 0);
        running = 0;
        clearModel();
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        chk("post_rst_addr", 128'(o_addra), 0);

        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(99) == 0), 1'($urandom_range(9) < 7), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("drain", 128'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
